alu_longop_unit: RTL

- Multi-cycle responder for the long ALU operations, DIV and POW, replacing the deep combinational paths in the datapath ALU.
- The datapath issues an operation with a start pulse, stalls while busy is high, and takes Result/ALUFlags on the done pulse.
- Operation encodings and the {N,Z,C,V} flag format are the same as the single-cycle ALU, so results and flags mux straight into the existing writeback and flag paths.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_longop_unit_if.sv | 26 ++
 rtl/alu_longop_unit_div_step.sv | 30 +++
 rtl/alu_longop_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions, long-op FSM states.
// Imported by the single-cycle ALU and by alu_longop_unit so encodings stay in step.
// Pure declarations; no logic, no latency.
package alu_pkg;

   // ALU op codes carried on ALUControl
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_DIV = 3'b101;
   localparam logic [2:0] ALU_POW = 3'b110;

   // Bit positions inside the {N,Z,C,V} flag nibble
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Default largest exponent POW computes before saturating
   localparam int MAX_EXP_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIV_RUN = 2'd1,
      ST_POW_RUN = 2'd2,
      ST_DONE    = 2'd3
   } longop_state_t;

endpackage

// File: rtl/alu_longop_unit_if.sv
// Request/response bundle between the datapath and the long-op unit.
// Datapath drives start/op/operands; the unit returns busy, done and results.
// No buffering: the datapath must stall while busy is high.
interface alu_longop_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       ALUControl;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Result;
   logic [3:0]       ALUFlags;
   logic             div_by_zero;

   modport master (
      output start, ALUControl, A, B,
      input  busy, done, Result, ALUFlags, div_by_zero
   );

   modport slave (
      input  start, ALUControl, A, B,
      output busy, done, Result, ALUFlags, div_by_zero
   );
endinterface

// File: rtl/alu_longop_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
// Purely combinational, zero latency.
// No handshake; the caller decides when to register the outputs.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic             msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] dvs_ext;

   assign shifted = {rem[WIDTH-1:0], msb};
   assign dvs_ext = {1'b0, divisor};

   // Keep the difference only when the divisor fits into the shifted remainder
   always_comb begin
      q_bit    = 1'b0;
      rem_next = shifted;
      if (shifted >= dvs_ext) begin
         q_bit    = 1'b1;
         rem_next = shifted - dvs_ext;
      end
   end

endmodule

// File: rtl/alu_longop_unit.sv
// Multi-cycle DIV (restoring, WIDTH cycles) and POW (one multiply per cycle) unit.
// Latency: DIV WIDTH+1 cycles, POW e+1 cycles, trivial cases 1 cycle to done.
// Backpressure: start only accepted in IDLE; ignored while busy or in DONE.
module alu_longop_unit
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int EXP_BITS = 4,
   parameter int MAX_EXP  = MAX_EXP_DEF
) (
   input  logic             clk,
   input  logic             reset,
   alu_longop_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   longop_state_t      state;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   dvd_quo;   // dividend bits shift out the top, quotient bits shift in below
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH-1:0]   base;
   logic [WIDTH-1:0]   acc;
   logic               ovf;
   logic [CW-1:0]      cnt;

   logic [WIDTH:0]     rem_nxt;
   logic               q_bit;
   logic [WIDTH-1:0]   quo_nxt;
   logic [2*WIDTH-1:0] prod;
   logic               prod_hi;
   logic [EXP_BITS-1:0] e_in;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (rem),
      .msb      (dvd_quo[WIDTH-1]),
      .divisor  (dvs),
      .rem_next (rem_nxt),
      .q_bit    (q_bit)
   );

   assign quo_nxt = {dvd_quo[WIDTH-2:0], q_bit};
   assign prod    = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base};
   assign prod_hi = |prod[2*WIDTH-1:WIDTH];
   assign e_in    = bus.B[EXP_BITS-1:0];

   function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] r, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_Z] = (r == '0);
      f[FLAG_C] = 1'b0;
      f[FLAG_V] = v;
      return f;
   endfunction

   // Control FSM with operand capture, iteration datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.Result      <= '0;
         bus.ALUFlags    <= 4'b0000;
         bus.div_by_zero <= 1'b0;
         rem             <= '0;
         dvd_quo         <= '0;
         dvs             <= '0;
         base            <= '0;
         acc             <= '0;
         ovf             <= 1'b0;
         cnt             <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  bus.div_by_zero <= 1'b0;
                  rem             <= '0;
                  dvd_quo         <= bus.A;
                  dvs             <= bus.B;
                  base            <= bus.A;
                  acc             <= WIDTH'(1);
                  ovf             <= 1'b0;
                  if (bus.ALUControl == ALU_DIV && bus.B != '0) begin
                     state    <= ST_DIV_RUN;
                     bus.busy <= 1'b1;
                     cnt      <= CW'(WIDTH);
                  end else if (bus.ALUControl == ALU_POW && e_in != '0 &&
                               int'(e_in) <= MAX_EXP) begin
                     state    <= ST_POW_RUN;
                     bus.busy <= 1'b1;
                     cnt      <= CW'(e_in);
                  end else begin
                     // Cases resolved without iterating finish in the next cycle
                     state    <= ST_DONE;
                     bus.done <= 1'b1;
                     if (bus.ALUControl == ALU_DIV) begin
                        bus.Result      <= '0;
                        bus.ALUFlags    <= flags_of('0, 1'b0);
                        bus.div_by_zero <= 1'b1;
                     end else if (bus.ALUControl == ALU_POW && e_in == '0) begin
                        bus.Result   <= WIDTH'(1);
                        bus.ALUFlags <= flags_of(WIDTH'(1), 1'b0);
                     end else if (bus.ALUControl == ALU_POW) begin
                        bus.Result   <= '1;
                        bus.ALUFlags <= flags_of('1, 1'b1);
                     end else begin
                        bus.Result   <= '0;
                        bus.ALUFlags <= flags_of('0, 1'b0);
                     end
                  end
               end
            end
            ST_DIV_RUN: begin
               rem     <= rem_nxt;
               dvd_quo <= quo_nxt;
               cnt     <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state        <= ST_DONE;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.Result   <= quo_nxt;
                  bus.ALUFlags <= flags_of(quo_nxt, 1'b0);
               end
            end
            ST_POW_RUN: begin
               acc <= prod[WIDTH-1:0];
               ovf <= ovf | prod_hi;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state        <= ST_DONE;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.Result   <= prod[WIDTH-1:0];
                  bus.ALUFlags <= flags_of(prod[WIDTH-1:0], ovf | prod_hi);
               end
            end
            ST_DONE: begin
               bus.done <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
